ahb_slave_responder: RTL and testbench

- AHB-Lite responder at the far end of the bus from the team's AHB master.
- Decodes address phases and holds a word-addressed register bank.
- Inserts a configurable number of wait states and returns OKAY or the two-cycle ERROR response.
- Serves as the bus-side target for master bring-up and as the AHB front end ahead of the APB bridge.

---
 rtl/ahb_pkg.sv | 34 +++
 rtl/ahb_byte_lane_decode.sv | 30 +++
 rtl/ahb_slave_responder.sv | 126 ++++++++++++
 tb/tb_ahb_slave_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite bus codes and responder state type
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
  function automatic logic trans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// rtl/ahb_byte_lane_decode.sv - transfer size and low address to byte-lane strobes
module ahb_byte_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] lanes,
  output logic       misalign
);

  // Little-endian lane select; oversize transfers get no lanes and are
  // rejected by the size check in the responder.
  always_comb begin
    lanes    = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        lanes    = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        lanes    = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_slave_responder.sv
// rtl/ahb_slave_responder.sv - AHB-Lite responder with register bank, wait states and ERROR response
module ahb_slave_responder
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 0
)(
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hselx,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic [31:0] Hrdata,
  output logic        Hreadyout,
  output logic        Hresp
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  resp_state_e      state;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] lat_idx;
  logic [3:0]       lat_lanes;
  logic             lat_write;
  logic [31:0]      bank [DEPTH];

  logic [31:0] offset;
  logic        in_range;
  logic [3:0]  lanes;
  logic        misalign;
  logic        addr_err;
  logic        phase_done;
  logic        accept;
  logic        commit;

  ahb_byte_lane_decode u_lane_decode (
    .hsize    (Hsize),
    .addr_lo  (Haddr[1:0]),
    .lanes    (lanes),
    .misalign (misalign)
  );

  // Offset is only meaningful when in range, which also bounds the index.
  assign offset     = Haddr - BASE_ADDR;
  assign in_range   = (Haddr >= BASE_ADDR) && (offset < SPAN);
  assign addr_err   = !in_range || (Hsize > HSIZE_WORD) || misalign;

  // A cycle completes the current data phase when idle, in ERR2, or when
  // the wait counter has run out; only then may a new address phase land.
  assign phase_done = (state == ST_IDLE) || (state == ST_ERR2) ||
                      ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign accept     = phase_done && Hselx && Hreadyin && trans_active(Htrans);
  assign commit     = (state == ST_WAIT) && (wait_cnt == 4'd0) && lat_write;

  // Response FSM with wait counter; outputs registered alongside the state.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_idx   <= '0;
      lat_lanes <= 4'b0000;
      lat_write <= 1'b0;
      Hreadyout <= 1'b1;
      Hresp     <= HRESP_OKAY;
    end else if (phase_done) begin
      if (accept && addr_err) begin
        state     <= ST_ERR1;
        wait_cnt  <= 4'd0;
        lat_write <= 1'b0;
        Hreadyout <= 1'b0;
        Hresp     <= HRESP_ERROR;
      end else if (accept) begin
        state     <= ST_WAIT;
        wait_cnt  <= WAIT_INIT;
        lat_idx   <= offset[IDX_W+1:2];
        lat_lanes <= lanes;
        lat_write <= Hwrite;
        Hreadyout <= (WAIT_INIT == 4'd0);
        Hresp     <= HRESP_OKAY;
      end else begin
        state     <= ST_IDLE;
        lat_write <= 1'b0;
        Hreadyout <= 1'b1;
        Hresp     <= HRESP_OKAY;
      end
    end else if (state == ST_ERR1) begin
      state     <= ST_ERR2;
      Hreadyout <= 1'b1;
      Hresp     <= HRESP_ERROR;
    end else begin
      wait_cnt  <= wait_cnt - 4'd1;
      Hreadyout <= (wait_cnt == 4'd1);
    end
  end

  // Bank storage; byte lanes commit on the edge that ends an OKAY write phase.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= 32'h0;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_lanes[b]) begin
          bank[lat_idx][8*b +: 8] <= Hwdata[8*b +: 8];
        end
      end
    end
  end

  // Read data is only driven during a read data phase so the bus sees zero otherwise.
  always_comb begin
    Hrdata = 32'h0;
    if ((state == ST_WAIT) && !lat_write) begin
      Hrdata = bank[lat_idx];
    end
  end

endmodule

// File: tb/tb_ahb_slave_responder.sv
// tb/tb_ahb_slave_responder.sv - directed scoreboard bench for ahb_slave_responder
module tb_ahb_slave_responder;
  import ahb_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        Hwrite;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        sel0, sel3;
  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3, resp0, resp3;

  int passed = 0;
  int total  = 0;
  logic [31:0] data_wdata;

  typedef struct {
    bit          d3;
    logic        exp_resp;
    int          exp_waits;
    logic [31:0] exp_rdata;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 Hclk = ~Hclk;

  ahb_slave_responder #(.WAIT_STATES(0)) dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .Hselx(sel0), .Hwrite(Hwrite), .Hreadyin(rdy0),
    .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hrdata(rdata0), .Hreadyout(rdy0), .Hresp(resp0)
  );

  ahb_slave_responder #(.WAIT_STATES(3)) dut3 (
    .Hclk(Hclk), .Hreset(Hreset), .Hselx(sel3), .Hwrite(Hwrite), .Hreadyin(rdy3),
    .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hrdata(rdata3), .Hreadyout(rdy3), .Hresp(resp3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic ready_of(input bit d3);
    return d3 ? rdy3 : rdy0;
  endfunction

  function automatic logic resp_of(input bit d3);
    return d3 ? resp3 : resp0;
  endfunction

  function automatic logic [31:0] rdata_of(input bit d3);
    return d3 ? rdata3 : rdata0;
  endfunction

  task automatic complete_prev();
    exp_t e;
    int   waits;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    waits = 0;
    while (ready_of(e.d3) !== 1'b1 && waits < 20) begin
      check({e.tag, "_resp_stall"}, 32'(resp_of(e.d3)), 32'(e.exp_resp));
      waits++;
      @(negedge Hclk);
    end
    check({e.tag, "_ready"}, 32'(ready_of(e.d3)), 32'd1);
    check({e.tag, "_waits"}, 32'(waits), 32'(e.exp_waits));
    check({e.tag, "_resp"}, 32'(resp_of(e.d3)), 32'(e.exp_resp));
    check({e.tag, "_rdata"}, rdata_of(e.d3), e.exp_rdata);
  endtask

  task automatic xfer(input string tag, input bit d3, input bit sel, input logic [1:0] trans,
                      input bit wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic rsp, input int waits,
                      input logic [31:0] rd);
    exp_t e;
    Hwdata = data_wdata;
    Htrans = trans;
    Hwrite = wr;
    Hsize  = size;
    Haddr  = addr;
    sel0   = sel & !d3;
    sel3   = sel & d3;
    complete_prev();
    e.d3 = d3; e.exp_resp = rsp; e.exp_waits = waits; e.exp_rdata = rd; e.tag = tag;
    sb.push_back(e);
    @(posedge Hclk);
    data_wdata = wdata;
    @(negedge Hclk);
  endtask

  task automatic flush();
    Hwdata = data_wdata;
    Htrans = HTRANS_IDLE;
    sel0   = 1'b0;
    sel3   = 1'b0;
    complete_prev();
    @(posedge Hclk);
    @(negedge Hclk);
  endtask

  initial begin
    Hreset = 1'b1; Hwrite = 1'b0; Htrans = HTRANS_IDLE; Hsize = HSIZE_WORD;
    Haddr = 32'h0; Hwdata = 32'h0; sel0 = 1'b0; sel3 = 1'b0; data_wdata = 32'h0;
    repeat (2) @(negedge Hclk);
    check("reset_ready0", 32'(rdy0), 32'd1);
    check("reset_resp0", 32'(resp0), 32'd0);
    check("reset_rdata0", rdata0, 32'h0);
    check("reset_ready3", 32'(rdy3), 32'd1);
    Hreset = 1'b0;
    @(negedge Hclk);

    // Asynchronous reset in the middle of a wait-stated write
    Haddr = 32'h8000_0000; Hsize = HSIZE_WORD; Hwrite = 1'b1; Htrans = HTRANS_NONSEQ; sel3 = 1'b1;
    @(posedge Hclk);
    @(negedge Hclk);
    Hwdata = 32'h1234_5678; sel3 = 1'b0; Htrans = HTRANS_IDLE;
    check("rst_in_wait", 32'(rdy3), 32'd0);
    #2 Hreset = 1'b1;
    #1;
    check("rst_async_ready", 32'(rdy3), 32'd1);
    check("rst_async_resp", 32'(resp3), 32'd0);
    check("rst_async_rdata", rdata3, 32'h0);
    @(negedge Hclk);
    Hreset = 1'b0;
    @(negedge Hclk);
    xfer("rst_rd0", 1, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_0000, 32'h0, 1'b0, 3, 32'h0);
    flush();

    // Byte write then word read
    xfer("byte_wr", 0, 1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h8000_0001, 32'h0000_A300, 1'b0, 0, 32'h0);
    xfer("byte_rd", 0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_0000, 32'h0, 1'b0, 0, 32'h0000_A300);
    flush();

    // Three wait states
    xfer("ws_wr", 1, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h8000_00A0, 32'h5A5A_1234, 1'b0, 3, 32'h0);
    xfer("ws_rd", 1, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_00A0, 32'h0, 1'b0, 3, 32'h5A5A_1234);
    flush();

    // ERROR responses and range boundaries
    xfer("err_oor", 0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_0100, 32'h0, 1'b1, 1, 32'h0);
    xfer("last_word", 0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_00FC, 32'h0, 1'b0, 0, 32'h0);
    xfer("err_below", 0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h7FFF_FFFC, 32'h0, 1'b1, 1, 32'h0);
    xfer("err_half", 0, 1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h8000_0003, 32'hFFFF_FFFF, 1'b1, 1, 32'h0);
    xfer("err_size", 0, 1, HTRANS_NONSEQ, 1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h0);
    xfer("err_nochg", 0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_0000, 32'h0, 1'b0, 0, 32'h0000_A300);
    flush();
    xfer("err_ws", 1, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_0002, 32'h0, 1'b1, 1, 32'h0);
    flush();

    // Back-to-back pipelined traffic
    xfer("pipe_wr", 0, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
    xfer("pipe_rd", 0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_0010, 32'h0, 1'b0, 0, 32'hDEAD_BEEF);
    xfer("half_wr", 0, 1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h8000_0012, 32'h1234_0000, 1'b0, 0, 32'h0);
    xfer("seq_wr", 0, 1, HTRANS_SEQ, 1, HSIZE_BYTE, 32'h8000_0013, 32'h5600_0000, 1'b0, 0, 32'h0);
    xfer("lane_rd", 0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_0010, 32'h0, 1'b0, 0, 32'h5634_BEEF);

    // Idle, busy and unselected cycles
    xfer("busy", 0, 1, HTRANS_BUSY, 1, HSIZE_WORD, 32'h8000_0010, 32'h0, 1'b0, 0, 32'h0);
    xfer("idle", 0, 1, HTRANS_IDLE, 1, HSIZE_WORD, 32'h8000_0010, 32'h0, 1'b0, 0, 32'h0);
    xfer("unsel", 0, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h8000_0010, 32'h0, 1'b0, 0, 32'h0);
    xfer("idle_rd", 0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8000_0010, 32'h0, 1'b0, 0, 32'h5634_BEEF);
    flush();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
